// File: rtl/mult_32bit_if.sv
// Operand/control/result bundle shared by the MultDiv arithmetic units.
// The master drives the operands and the start pulse; the slave returns the product.
interface mult_32bit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/mult_32bit.sv
// Sequential signed multiplier using radix-4 modified Booth recoding.
// Retires two multiplier bits per clock; WIDTH/2 iterations per product.
module mult_32bit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          resetn,
    mult_32bit_if.slave   bus
);
    localparam int ITER  = WIDTH / 2;
    localparam int CNT_W = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  r_state, w_next;
    logic [WIDTH-1:0]        r_m;
    logic signed [WIDTH+1:0] r_acc;
    logic [WIDTH-1:0]        r_q;
    logic                    r_qm1;
    logic [CNT_W-1:0]        r_cnt;
    logic [WIDTH-1:0]        r_result;
    logic                    r_exc;
    logic                    r_rdy;

    logic signed [WIDTH+1:0] w_m_ext;
    logic signed [WIDTH+1:0] w_term;
    logic signed [WIDTH+1:0] w_acc_sum;
    logic signed [WIDTH+1:0] w_acc_sh;
    logic [WIDTH-1:0]        w_q_sh;
    logic                    w_qm1_sh;
    logic [WIDTH:0]          w_p_hi;
    logic                    w_last;

    function automatic logic signed [WIDTH+1:0] booth_term(
        input logic [2:0]              sel,
        input logic signed [WIDTH+1:0] m
    );
        case (sel)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    // Product fits in WIDTH bits only when the top WIDTH+1 bits are all sign copies.
    function automatic logic ovf(input logic [WIDTH:0] hi);
        return ~(&hi | ~|hi);
    endfunction

    assign w_m_ext   = {{2{r_m[WIDTH-1]}}, r_m};
    assign w_term    = booth_term({r_q[1:0], r_qm1}, w_m_ext);
    assign w_acc_sum = r_acc + w_term;
    assign w_acc_sh  = {{2{w_acc_sum[WIDTH+1]}}, w_acc_sum[WIDTH+1:2]};
    assign w_q_sh    = {w_acc_sum[1:0], r_q[WIDTH-1:2]};
    assign w_qm1_sh  = r_q[1];
    assign w_p_hi    = {w_acc_sh[WIDTH-1:0], w_q_sh[WIDTH-1]};
    assign w_last    = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        if (bus.ctrl_MULT) begin
            w_next = BUSY;
        end else begin
            case (r_state)
                BUSY:    if (w_last) w_next = DONE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_m      <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (bus.ctrl_MULT) begin
                r_m   <= bus.data_operandA;
                r_acc <= '0;
                r_q   <= bus.data_operandB;
                r_qm1 <= 1'b0;
                r_cnt <= '0;
                r_rdy <= 1'b0;
            end else if (r_state == BUSY) begin
                r_acc <= w_acc_sh;
                r_q   <= w_q_sh;
                r_qm1 <= w_qm1_sh;
                r_cnt <= r_cnt + 1'b1;
                // After the last shift {acc[WIDTH-1:0], q} holds the full product.
                if (w_last) begin
                    r_result <= w_q_sh;
                    r_exc    <= ovf(w_p_hi);
                    r_rdy    <= 1'b1;
                end
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_mult_32bit.sv
// Self-checking bench for mult_32bit: directed table, restart/reset sequences,
// and randomized operands compared against a 64-bit arithmetic product.
module tb_mult_32bit;
    localparam int W   = 32;
    localparam int LAT = W / 2;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;

    mult_32bit_if #(.WIDTH(W)) bus ();

    mult_32bit #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         exc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact signed product, then range test against WIDTH-bit limits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic exc);
        longint p;
        p   = longint'($signed(a)) * longint'($signed(b));
        res = p[W-1:0];
        exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = ~a;
        bus.data_operandB = b ^ 32'h5A5A_A5A5;
    endtask

    // Called right after start_op; returns number of edges after the start edge.
    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_res, input logic e_exc, input bit hold_chk);
        int lat;
        start_op(a, b);
        check({tag, "_rdy_drop"}, 64'(bus.data_resultRDY), 64'd0);
        wait_rdy(lat);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_result"}, 64'(bus.data_result), 64'(e_res));
        check({tag, "_exc"}, 64'(bus.data_exception), 64'(e_exc));
        if (hold_chk) begin
            repeat (3) @(negedge clock);
            check({tag, "_hold_rdy"}, 64'(bus.data_resultRDY), 64'd1);
            check({tag, "_hold_res"}, 64'(bus.data_result), 64'(e_res));
        end
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        bit seen;
        logic [W-1:0] ra, rb, er;
        logic ee;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{32'd3,          32'd4,          32'h0000_000C, 1'b0};
        vecs[1] = '{-32'sd7,        32'd6,          32'hFFFF_FFD6, 1'b0};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE, 1'b1};
        vecs[4] = '{32'h0000_FFFF,  32'h0000_FFFF,  32'hFFFE_0001, 1'b1};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 1'b1};

        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        resetn            = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_result", 64'(bus.data_result), 64'd0);
        check("reset_exc", 64'(bus.data_exception), 64'd0);
        check("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_rdy", 64'(bus.data_resultRDY), 64'd0);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, 1'b1);

        // Restart while busy: only the second operation may complete.
        start_op(32'd5, 32'd5);
        repeat (5) @(negedge clock);
        check("restart_busy_rdy", 64'(bus.data_resultRDY), 64'd0);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rdy(lat);
        check("restart_latency", 64'(lat), 64'(LAT));
        check("restart_result", 64'(bus.data_result), 64'd1);
        check("restart_exc", 64'(bus.data_exception), 64'd0);

        // Reset in the middle of an operation clears outputs at once.
        start_op(32'd1234, 32'd77);
        repeat (8) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_result", 64'(bus.data_result), 64'd0);
        check("midrst_exc", 64'(bus.data_exception), 64'd0);
        check("midrst_rdy", 64'(bus.data_resultRDY), 64'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY !== 1'b0) seen = 1'b1;
        end
        check("postrst_no_rdy", 64'(seen), 64'd0);
        do_op("postrst", 32'd1234, 32'd77, 32'd95018, 1'b0, 1'b1);

        // Randomized pairs, biased toward 0, +-1, min and max.
        for (int n = 0; n < 2500; n++) begin
            for (int k = 0; k < 2; k++) begin
                logic [W-1:0] v;
                case ($urandom_range(0, 9))
                    0:       v = 32'h0000_0000;
                    1:       v = 32'h0000_0001;
                    2:       v = 32'hFFFF_FFFF;
                    3:       v = 32'h8000_0000;
                    4:       v = 32'h7FFF_FFFF;
                    5:       v = W'($signed(16'($urandom)));
                    default: v = $urandom;
                endcase
                if (k == 0) ra = v; else rb = v;
            end
            model(ra, rb, er, ee);
            do_op($sformatf("rnd%0d", n), ra, rb, er, ee, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
